// File: rtl/rom_arb_pkg.sv
// Shared constants and helpers for the two-port ROM arbiter.
// Port indices and the word-index range check live here.
package rom_arb_pkg;

  localparam int PORT_FETCH = 0;
  localparam int PORT_LOAD  = 1;
  localparam int NPORTS     = 2;

  // The compare uses the full 30-bit word index, so high addresses cannot wrap into range.
  function automatic logic word_in_range(input logic [31:0] addr, input int unsigned length);
    logic [31:0] wordIdx;
    wordIdx = addr >> 2;
    return (wordIdx < length);
  endfunction

endpackage

// File: rtl/rom_port_arbiter_rsp_slot.sv
// Single-entry response holding register for one arbiter port.
// Flush beats load beats drain; contents hold until consumed.
module rsp_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             drain_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             err_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             err_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    err_d   = err_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      err_d   = err_i;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign err_o   = err_q;

endmodule

// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing one combinational-read ROM between fetch (port 0)
// and load (port 1), with a registered response slot per port.
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned LENGTH = 8,
  parameter int          WIDTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NPORTS-1:0] req_valid,
  input  logic [31:0]       req_addr0,
  input  logic [31:0]       req_addr1,
  output logic [NPORTS-1:0] req_ready,
  output logic [NPORTS-1:0] rsp_valid,
  output logic [WIDTH-1:0]  rsp_data0,
  output logic [WIDTH-1:0]  rsp_data1,
  output logic [NPORTS-1:0] rsp_err,
  input  logic [NPORTS-1:0] rsp_ready,
  input  logic              flush0,
  output logic [31:0]       rom_addr,
  input  logic [WIDTH-1:0]  rom_q
);

  logic              lastGrant_q, lastGrant_d;
  logic [NPORTS-1:0] slotFree;
  logic [NPORTS-1:0] eligible;
  logic [NPORTS-1:0] grant;
  logic [NPORTS-1:0] drain;
  logic [WIDTH-1:0]  loadData;
  logic              loadErr;

  // A slot may be refilled in the same cycle its consumer drains it.
  always_comb begin
    slotFree[PORT_FETCH] = (!rsp_valid[PORT_FETCH] | rsp_ready[PORT_FETCH]) & !flush0;
    slotFree[PORT_LOAD]  = !rsp_valid[PORT_LOAD] | rsp_ready[PORT_LOAD];
    eligible             = req_valid & slotFree & {NPORTS{!rst}};
    drain                = rsp_ready & rsp_valid;
  end

  always_comb begin
    grant       = eligible;
    lastGrant_d = lastGrant_q;
    if (eligible[PORT_FETCH] && eligible[PORT_LOAD]) begin
      grant = lastGrant_q ? 2'b01 : 2'b10;
    end
    if (grant[PORT_LOAD]) begin
      lastGrant_d = 1'b1;
    end else if (grant[PORT_FETCH]) begin
      lastGrant_d = 1'b0;
    end
  end

  always_comb begin
    rom_addr = 32'h0;
    if (grant[PORT_LOAD]) begin
      rom_addr = req_addr1;
    end else if (grant[PORT_FETCH]) begin
      rom_addr = req_addr0;
    end
    loadErr  = !word_in_range(rom_addr, LENGTH);
    loadData = loadErr ? '0 : rom_q;
  end

  assign req_ready = grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      lastGrant_q <= 1'b1;
    end else begin
      lastGrant_q <= lastGrant_d;
    end
  end

  rsp_slot #(.WIDTH(WIDTH)) u_slotFetch (
    .clk     (clk),
    .rst     (rst),
    .load_i  (grant[PORT_FETCH]),
    .drain_i (drain[PORT_FETCH]),
    .flush_i (flush0),
    .data_i  (loadData),
    .err_i   (loadErr),
    .valid_o (rsp_valid[PORT_FETCH]),
    .data_o  (rsp_data0),
    .err_o   (rsp_err[PORT_FETCH])
  );

  rsp_slot #(.WIDTH(WIDTH)) u_slotLoad (
    .clk     (clk),
    .rst     (rst),
    .load_i  (grant[PORT_LOAD]),
    .drain_i (drain[PORT_LOAD]),
    .flush_i (1'b0),
    .data_i  (loadData),
    .err_i   (loadErr),
    .valid_o (rsp_valid[PORT_LOAD]),
    .data_o  (rsp_data1),
    .err_o   (rsp_err[PORT_LOAD])
  );

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter: fetch streaming, round-robin contention,
// range errors, slot hold, fetch flush and mid-traffic reset.
module tb_rom_port_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  reqValid;
  logic [31:0] reqAddr0;
  logic [31:0] reqAddr1;
  logic [1:0]  reqReady;
  logic [1:0]  rspValid;
  logic [31:0] rspData0;
  logic [31:0] rspData1;
  logic [1:0]  rspErr;
  logic [1:0]  rspReady;
  logic        flush0;
  logic [31:0] romAddr;
  logic [31:0] romQ;

  logic [31:0] mem [8];

  int testCount = 0;
  int failCount = 0;

  rom_port_arbiter #(.LENGTH(8), .WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (reqValid),
    .req_addr0 (reqAddr0),
    .req_addr1 (reqAddr1),
    .req_ready (reqReady),
    .rsp_valid (rspValid),
    .rsp_data0 (rspData0),
    .rsp_data1 (rspData1),
    .rsp_err   (rspErr),
    .rsp_ready (rspReady),
    .flush0    (flush0),
    .rom_addr  (romAddr),
    .rom_q     (romQ)
  );

  // Model of the attached ROM; its index wraps, so out-of-range reads return nonzero words.
  assign romQ = mem[romAddr[4:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic [1:0] rv, input logic [31:0] a0,
                               input logic [31:0] a1, input logic [1:0] rr, input logic fl);
    @(negedge clk);
    rst      = r;
    reqValid = rv;
    reqAddr0 = a0;
    reqAddr1 = a1;
    rspReady = rr;
    flush0   = fl;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) mem[k] = 32'hC0DE_0000 + k;
    rst = 1'b1; reqValid = 2'b00; reqAddr0 = 32'h0; reqAddr1 = 32'h0;
    rspReady = 2'b00; flush0 = 1'b0;

    // Reset: no grants while rst is high
    applyStimulus(1, 2'b11, 32'h0, 32'h4, 2'b11, 0);
    checkOutput("rst_ready", reqReady, 2'b00);

    // Fetch-only stream at 0, 4, 0xB
    applyStimulus(0, 2'b01, 32'h0, 32'h0, 2'b11, 0);
    checkOutput("rst_valid", rspValid, 2'b00);
    checkOutput("rst_err", rspErr, 2'b00);
    checkOutput("rst_data0", rspData0, 32'h0);
    checkOutput("rst_data1", rspData1, 32'h0);
    checkOutput("f_ready_a", reqReady, 2'b01);
    checkOutput("f_addr_a", romAddr, 32'h0);
    applyStimulus(0, 2'b01, 32'h4, 32'h0, 2'b11, 0);
    checkOutput("f_data_a", rspData0, 32'hC0DE_0000);
    checkOutput("f_valid_a", rspValid, 2'b01);
    checkOutput("f_err_a", rspErr, 2'b00);
    checkOutput("f_ready_b", reqReady, 2'b01);
    checkOutput("f_addr_b", romAddr, 32'h4);
    applyStimulus(0, 2'b01, 32'hB, 32'h0, 2'b11, 0);
    checkOutput("f_data_b", rspData0, 32'hC0DE_0001);
    checkOutput("f_ready_c", reqReady, 2'b01);
    checkOutput("f_addr_c", romAddr, 32'hB);
    applyStimulus(0, 2'b00, 32'h0, 32'h0, 2'b11, 0);
    checkOutput("f_data_c", rspData0, 32'hC0DE_0002);
    checkOutput("f_valid_c", rspValid, 2'b01);
    checkOutput("f_idle_ready", reqReady, 2'b00);
    checkOutput("f_idle_addr", romAddr, 32'h0);
    applyStimulus(0, 2'b00, 32'h0, 32'h0, 2'b11, 0);
    checkOutput("f_drained", rspValid, 2'b00);
    checkOutput("f_data_hold", rspData0, 32'hC0DE_0002);

    // Contention after reset: grants 0,1,0
    applyStimulus(1, 2'b00, 32'h0, 32'h0, 2'b11, 0);
    applyStimulus(0, 2'b11, 32'h8, 32'hC, 2'b11, 0);
    checkOutput("rr_ready_1", reqReady, 2'b01);
    checkOutput("rr_addr_1", romAddr, 32'h8);
    applyStimulus(0, 2'b11, 32'h10, 32'hC, 2'b11, 0);
    checkOutput("rr_ready_2", reqReady, 2'b10);
    checkOutput("rr_addr_2", romAddr, 32'hC);
    checkOutput("rr_valid_2", rspValid, 2'b01);
    checkOutput("rr_data0_2", rspData0, 32'hC0DE_0002);
    applyStimulus(0, 2'b11, 32'h10, 32'h14, 2'b11, 0);
    checkOutput("rr_ready_3", reqReady, 2'b01);
    checkOutput("rr_addr_3", romAddr, 32'h10);
    checkOutput("rr_valid_3", rspValid, 2'b10);
    checkOutput("rr_data1_3", rspData1, 32'hC0DE_0003);
    applyStimulus(0, 2'b00, 32'h0, 32'h0, 2'b11, 0);
    checkOutput("rr_valid_4", rspValid, 2'b01);
    checkOutput("rr_data0_4", rspData0, 32'hC0DE_0004);

    // Port 1 range boundary and far out-of-range address
    applyStimulus(0, 2'b10, 32'h0, 32'h1C, 2'b11, 0);
    checkOutput("rng_valid_0", rspValid, 2'b00);
    checkOutput("rng_ready_a", reqReady, 2'b10);
    checkOutput("rng_addr_a", romAddr, 32'h1C);
    applyStimulus(0, 2'b10, 32'h0, 32'h20, 2'b11, 0);
    checkOutput("rng_data_last", rspData1, 32'hC0DE_0007);
    checkOutput("rng_err_last", rspErr, 2'b00);
    checkOutput("rng_addr_b", romAddr, 32'h20);
    applyStimulus(0, 2'b10, 32'h0, 32'h8000_0004, 2'b11, 0);
    checkOutput("rng_data_oob", rspData1, 32'h0);
    checkOutput("rng_err_oob", rspErr, 2'b10);
    checkOutput("rng_valid_oob", rspValid, 2'b10);
    applyStimulus(0, 2'b00, 32'h0, 32'h0, 2'b11, 0);
    checkOutput("rng_data_far", rspData1, 32'h0);
    checkOutput("rng_err_far", rspErr, 2'b10);

    // Port 0 consumer stalls for three cycles, then drains and refills
    applyStimulus(0, 2'b11, 32'h14, 32'h18, 2'b10, 0);
    checkOutput("hold_valid_0", rspValid, 2'b00);
    checkOutput("hold_ready_0", reqReady, 2'b01);
    checkOutput("hold_addr_0", romAddr, 32'h14);
    applyStimulus(0, 2'b11, 32'h4, 32'h18, 2'b10, 0);
    checkOutput("hold_ready_1", reqReady, 2'b10);
    checkOutput("hold_data0_1", rspData0, 32'hC0DE_0005);
    applyStimulus(0, 2'b11, 32'h4, 32'h18, 2'b10, 0);
    checkOutput("hold_ready_2", reqReady, 2'b10);
    checkOutput("hold_data0_2", rspData0, 32'hC0DE_0005);
    checkOutput("hold_valid_2", rspValid, 2'b11);
    checkOutput("hold_data1_2", rspData1, 32'hC0DE_0006);
    applyStimulus(0, 2'b11, 32'h4, 32'h18, 2'b10, 0);
    checkOutput("hold_ready_3", reqReady, 2'b10);
    checkOutput("hold_data0_3", rspData0, 32'hC0DE_0005);
    applyStimulus(0, 2'b11, 32'h4, 32'h18, 2'b11, 0);
    checkOutput("hold_refill_ready", reqReady, 2'b01);
    checkOutput("hold_refill_addr", romAddr, 32'h4);
    applyStimulus(0, 2'b00, 32'h0, 32'h0, 2'b11, 0);
    checkOutput("hold_refill_valid", rspValid, 2'b01);
    checkOutput("hold_refill_data", rspData0, 32'hC0DE_0001);
    applyStimulus(0, 2'b00, 32'h0, 32'h0, 2'b11, 0);
    checkOutput("hold_empty", rspValid, 2'b00);

    // Fetch flush with a full slot and a pending fetch; load still granted
    applyStimulus(0, 2'b01, 32'h8, 32'h0, 2'b11, 0);
    checkOutput("fl_ready_pre", reqReady, 2'b01);
    applyStimulus(0, 2'b11, 32'hC, 32'h10, 2'b11, 1);
    checkOutput("fl_valid_pre", rspValid, 2'b01);
    checkOutput("fl_data0_pre", rspData0, 32'hC0DE_0002);
    checkOutput("fl_ready", reqReady, 2'b10);
    checkOutput("fl_addr", romAddr, 32'h10);
    applyStimulus(0, 2'b00, 32'h0, 32'h0, 2'b11, 0);
    checkOutput("fl_valid_post", rspValid, 2'b10);
    checkOutput("fl_data1_post", rspData1, 32'hC0DE_0004);
    checkOutput("fl_data0_post", rspData0, 32'hC0DE_0002);
    applyStimulus(0, 2'b00, 32'h0, 32'h0, 2'b11, 0);
    checkOutput("fl_empty", rspValid, 2'b00);

    // Reset with both slots full, pointer last on port 0
    applyStimulus(0, 2'b11, 32'h0, 32'h4, 2'b00, 0);
    checkOutput("rs_ready_a", reqReady, 2'b01);
    applyStimulus(0, 2'b11, 32'h8, 32'h4, 2'b00, 0);
    checkOutput("rs_ready_b", reqReady, 2'b10);
    applyStimulus(0, 2'b11, 32'h8, 32'h4, 2'b01, 0);
    checkOutput("rs_ready_c", reqReady, 2'b01);
    checkOutput("rs_addr_c", romAddr, 32'h8);
    checkOutput("rs_data1_c", rspData1, 32'hC0DE_0001);
    applyStimulus(0, 2'b00, 32'h0, 32'h0, 2'b00, 0);
    checkOutput("rs_full", rspValid, 2'b11);
    checkOutput("rs_data0_full", rspData0, 32'hC0DE_0002);
    applyStimulus(1, 2'b11, 32'h0, 32'h4, 2'b00, 0);
    checkOutput("rs_ready_inrst", reqReady, 2'b00);
    applyStimulus(0, 2'b11, 32'h0, 32'h4, 2'b11, 0);
    checkOutput("rs_valid_post", rspValid, 2'b00);
    checkOutput("rs_data0_post", rspData0, 32'h0);
    checkOutput("rs_data1_post", rspData1, 32'h0);
    checkOutput("rs_err_post", rspErr, 2'b00);
    checkOutput("rs_first_grant", reqReady, 2'b01);
    applyStimulus(0, 2'b00, 32'h0, 32'h0, 2'b11, 0);
    checkOutput("rs_resp_valid", rspValid, 2'b01);
    checkOutput("rs_resp_data", rspData0, 32'hC0DE_0000);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares one combinational-read instruction ROM (`rom`, word-addressed by addr[31:2]) between two requesters: port 0 is instruction fetch, port 1 is data load.
- Sits between the core's fetch/load units and the `rom` instance.
- Arbitrates requests round-robin.
- Registers each port's response in a skid slot held until consumed.
- Flags out-of-range addresses.
- Supports a fetch-side flush for branch redirects.

Parameters:
- LENGTH, 8, ROM depth in words; must match the attached `rom`.
- WIDTH, 32, ROM word width in bits.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-port request valid; bit 0 = fetch, bit 1 = load.
- req_addr0  in  32  port 0 byte address.
- req_addr1  in  32  port 1 byte address.
- req_ready  out  2  per-port request accepted this cycle (the grant).
- rsp_valid  out  2  per-port response slot full.
- rsp_data0  out  WIDTH  port 0 response word.
- rsp_data1  out  WIDTH  port 1 response word.
- rsp_err  out  2  per-port: response came from an out-of-range address.
- rsp_ready  in  2  per-port consumer takes the response.
- flush0  in  1  discard port 0 slot; block any port 0 grant this cycle.
- rom_addr  out  32  address driven to rom.addr.
- rom_q  in  WIDTH  rom.q.

Behaviour:
- **Reset** (rst=1 at posedge):
  - rsp_valid=0, rsp_err=0, rsp_data0/1=0.
  - Round-robin pointer last_grant=1, so port 0 has priority on the first contended cycle.
  - req_ready is combinational and is 0 for both ports while rst=1.
  - Reset mid-transaction drops any in-flight or held response.
- **Slot free:** free[i] = !rsp_valid[i] | rsp_ready[i]. Same-cycle drain and refill is allowed. For port 0, free also requires !flush0.
- **Eligibility:** eligible[i] = req_valid[i] & free[i].
- **Grant rule:** at most one grant per cycle.
  - Only one port eligible: that port is granted.
  - Both eligible: the port != last_grant is granted.
  - last_grant updates to the granted port only on a grant.
- **Outputs on grant:**
  - req_ready[g]=1.
  - rom_addr = granted port's address.
  - With no grant, rom_addr = 32'h0.
- **Latency:** 1 cycle. On the posedge ending the grant cycle:
  - rsp_valid[g] <= 1.
  - rsp_data_g <= rom_q, or 0 if out of range.
  - rsp_err[g] <= (req_addr_g[31:2] >= LENGTH).
- **Address rules:**
  - addr[1:0] are ignored.
  - The range compare is on the full 30-bit word index, so wrap is impossible.
- **Consume:** rsp_ready[i] & rsp_valid[i] with no new grant to i gives rsp_valid[i] <= 0. rsp_data/err hold their last values.
- **Hold:** while rsp_valid[i]=1 and rsp_ready[i]=0, slot contents are stable and port i gets no grant.
- **flush0:**
  - rsp_valid[0] <= 0.
  - No port 0 grant that cycle.
  - Port 1 may still be granted.
  - flush0 with rsp_ready[0]=1: the flush wins; the data is dropped.
- **Throughput:** a port with an always-ready consumer sustains 1 response/cycle when uncontended. Under contention, each port gets 1 response per 2 cycles.
- **Safety:** no combinational path from rsp_ready to rsp_data.

Decomposition:
- Package `rom_arb_pkg`:
  - Constants PORT_FETCH=0, PORT_LOAD=1, NPORTS=2.
  - Function word_in_range(addr, LENGTH).
- Sub-module `rsp_slot`: one per port. A single-entry register holding valid/data/err, with inputs load, drain and flush.

Test Plan:
- Reset, then port 0 only, addr 0,4,8 back-to-back with rsp_ready0=1 -> req_ready0=1 every cycle; rsp_data0 = mem[0],mem[1],mem[2] one cycle after each; rsp_err0=0.
- Both ports request every cycle, both ready -> grants alternate 0,1,0,1 starting with port 0 after reset; rom_addr follows the granted address.
- Port 1 request at addr 0x1C, then 0x20 (LENGTH=8) -> rsp_data1=mem[7], err=0; then rsp_data1=0, err=1.
- Port 0 rsp_ready0=0 for 3 cycles while req_valid0=1 -> rsp_data0 stable, req_ready0=0; port 1 still granted each cycle; after ready rises, drain and refill occur in the same cycle.
- flush0 asserted with rsp_valid0=1 and req_valid0=1 -> next cycle rsp_valid0=0; no port 0 grant that cycle; concurrent port 1 request granted.
- rst asserted while both slots are full -> next cycle all rsp_valid=0; the first contended grant after reset goes to port 0.
